fetch_stage: RTL and testbench

Instruction fetch stage of the 5-stage pipeline. It owns the PC, issues addresses to a synchronous 1-cycle-latency instruction memory, and drives the F/D pipeline register consumed by decode. It obeys the `f_stall` and `fd_flush` controls produced by `control_flow` and accepts a PC redirect from execute. A one-entry hold buffer ensures no fetched word is lost or duplicated across stalls.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_hold_buf.sv | 67 ++++++
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and types for the instruction fetch stage
//               and its consumers (decode reads fd_reg_t).
// Contents    : XLEN_DEF, RESET_PC_DEF, NOP_INSTR, PC_INC, fd_reg_t
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned          XLEN_DEF     = 32;
  localparam logic [XLEN_DEF-1:0]  RESET_PC_DEF = 32'h0000_0000;
  // addi x0, x0, 0 -- the canonical bubble instruction
  localparam logic [31:0]          NOP_INSTR    = 32'h0000_0013;
  localparam int unsigned          PC_INC       = 4;

  // F/D pipeline register as seen by decode
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         instr;
  } fd_reg_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_hold_buf
// Description : One-entry skid buffer that parks an instruction returned by
//               memory while the F/D register cannot accept it.
// Ports       : clk_i, rst_i        - clock, async active-high reset
//               capture_i           - load pc_i/instr_i, mark valid
//               drain_i             - entry consumed, clear valid
//               kill_i              - discard entry (highest priority)
//               pc_i, instr_i       - incoming fetched word
//               valid_o, pc_o, instr_o - buffered word
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            capture_i,
  input  logic            drain_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, issues reads to a
//               1-cycle-latency synchronous instruction memory and drives the
//               F/D register. A one-entry hold buffer keeps the in-flight
//               word when stall/flush arrives while a read is outstanding.
// Ports       : clk_i, rst_i                 - clock, async active-high reset
//               f_stall_i, fd_flush_i        - hazard controls
//               redirect_valid_i/redirect_pc_i - execute-stage PC redirect
//               imem_req_o, imem_addr_o, imem_rdata_i - instruction memory
//               fd_valid_o, fd_pc_o, fd_instr_o - F/D register
// Options     : FETCH_PERF_EN adds fetch_cnt_o / bubble_cnt_o counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_stall_i,
  input  logic            fd_flush_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            fd_valid_o,
  output logic [XLEN-1:0] fd_pc_o,
  output logic [31:0]     fd_instr_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     bubble_cnt_o
`endif
);

  logic            hold;
  logic            issue;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            fd_valid_q, fd_valid_d;
  logic [XLEN-1:0] fd_pc_q, fd_pc_d;
  logic [31:0]     fd_instr_q, fd_instr_d;
  logic            fd_load_valid;

  logic            hb_capture, hb_drain;
  logic            hb_valid;
  logic [XLEN-1:0] hb_pc;
  logic [31:0]     hb_instr;

  // Stall and flush look identical from the fetch side: nothing new issues.
  assign hold  = f_stall_i | fd_flush_i;
  assign issue = !hold && !redirect_valid_i;

  assign imem_req_o  = issue && !rst_i;
  assign imem_addr_o = pc_q;

  // PC / request-in-flight tracking
  always_comb begin
    pc_d        = pc_q;
    req_valid_d = 1'b0;
    req_pc_d    = req_pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (issue) begin
      pc_d        = pc_q + XLEN'(PC_INC);
      req_valid_d = 1'b1;
      req_pc_d    = pc_q;
    end
  end

  // A returning word that F/D cannot take is parked; it is released as soon
  // as hold drops. No issue happens while it fills, so the buffer and a new
  // return never compete for F/D.
  assign hb_capture = req_valid_q && hold && !redirect_valid_i;
  assign hb_drain   = hb_valid && !hold && !redirect_valid_i;

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture_i (hb_capture),
    .drain_i   (hb_drain),
    .kill_i    (redirect_valid_i),
    .pc_i      (req_pc_q),
    .instr_i   (imem_rdata_i),
    .valid_o   (hb_valid),
    .pc_o      (hb_pc),
    .instr_o   (hb_instr)
  );

  // F/D register: redirect > flush > stall > load (buffer first) > bubble
  always_comb begin
    fd_valid_d    = 1'b0;
    fd_pc_d       = '0;
    fd_instr_d    = NOP_INSTR;
    fd_load_valid = 1'b0;
    if (redirect_valid_i || fd_flush_i) begin
      fd_valid_d = 1'b0;
    end else if (f_stall_i) begin
      fd_valid_d = fd_valid_q;
      fd_pc_d    = fd_pc_q;
      fd_instr_d = fd_instr_q;
    end else if (hb_valid) begin
      fd_valid_d    = 1'b1;
      fd_pc_d       = hb_pc;
      fd_instr_d    = hb_instr;
      fd_load_valid = 1'b1;
    end else if (req_valid_q) begin
      fd_valid_d    = 1'b1;
      fd_pc_d       = req_pc_q;
      fd_instr_d    = imem_rdata_i;
      fd_load_valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      fd_valid_q  <= 1'b0;
      fd_pc_q     <= '0;
      fd_instr_q  <= NOP_INSTR;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      fd_valid_q  <= fd_valid_d;
      fd_pc_q     <= fd_pc_d;
      fd_instr_q  <= fd_instr_d;
    end
  end

  assign fd_valid_o = fd_valid_q;
  assign fd_pc_o    = fd_pc_q;
  assign fd_instr_o = fd_instr_q;

`ifdef FETCH_PERF_EN
  // Bubble counting skips the two pipeline-fill cycles after reset release,
  // which are bubbles by construction rather than by hazard.
  logic [1:0]  warm_q, warm_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    warm_d       = warm_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (warm_q != 2'd2) begin
      warm_d = warm_q + 2'd1;
    end
    if (fd_load_valid && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if ((warm_q == 2'd2) && !fd_valid_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      warm_q       <= 2'd0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      warm_q       <= warm_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. A behavioural
//               1-cycle instruction memory returns addr ^ 0xDEAD0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        f_stall_i = 1'b0;
  logic        fd_flush_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        fd_valid_o;
  logic [31:0] fd_pc_o;
  logic [31:0] fd_instr_o;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] bubble_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .f_stall_i        (f_stall_i),
    .fd_flush_i       (fd_flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .fd_valid_o       (fd_valid_o),
    .fd_pc_o          (fd_pc_o),
    .fd_instr_o       (fd_instr_o)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o      (fetch_cnt_o),
    .bubble_cnt_o     (bubble_cnt_o)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Synchronous memory with one cycle of read latency
  always @(posedge clk_i) begin
    if (imem_req_o) imem_rdata_i <= mem_word(imem_addr_o);
  end

  // Advance to the next cycle: inputs are driven 1 time unit after the edge
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Hold reset for two edges, release; returns at the start of cycle 0
  task automatic do_reset();
    rst_i = 1'b1;
    f_stall_i = 1'b0;
    fd_flush_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    n_vec++;
    if ({fd_valid_o, fd_pc_o, fd_instr_o} !== {1'b0, 32'h0, NOP_INSTR}) begin
      n_err++;
      $display("FAIL reset_fd: got v=%0b pc=%h ins=%h want v=0 pc=0 ins=%h",
               fd_valid_o, fd_pc_o, fd_instr_o, NOP_INSTR);
    end
    n_vec++;
    if ({imem_req_o, imem_addr_o} !== {1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_imem: got req=%0b addr=%h want req=0 addr=0",
               imem_req_o, imem_addr_o);
    end
  endtask

  // F/D in cycle c shows the word issued in cycle c-2
  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      #1;
      n_vec++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 32'(4 * c)}) begin
        n_err++;
        $display("FAIL stream_issue c=%0d: got req=%0b addr=%h want req=1 addr=%h",
                 c, imem_req_o, imem_addr_o, 32'(4 * c));
      end
      n_vec++;
      if (c < 2) begin
        if (fd_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL stream_fill c=%0d: got v=%0b want v=0", c, fd_valid_o);
        end
      end else if ({fd_valid_o, fd_pc_o, fd_instr_o} !==
                   {1'b1, 32'(4 * (c - 2)), mem_word(32'(4 * (c - 2)))}) begin
        n_err++;
        $display("FAIL stream_fd c=%0d: got v=%0b pc=%h ins=%h want pc=%h",
                 c, fd_valid_o, fd_pc_o, fd_instr_o, 32'(4 * (c - 2)));
      end
      next_cycle();
    end
  endtask

  // Stall cycles 4..6: F/D holds pc 8, word for pc 12 parks in the buffer,
  // then 12, 16, 20 follow back to back from cycle 8.
  task automatic test_stall();
    logic [31:0] exp_pc;
    logic        exp_req;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      f_stall_i = (c >= 4 && c <= 6);
      #1;
      exp_req = !(c >= 4 && c <= 6);
      if (c <= 7) exp_pc = (c < 4) ? 32'(4 * (c - 2)) : 32'h8;
      else        exp_pc = 32'(4 * (c - 5));
      n_vec++;
      if (imem_req_o !== exp_req) begin
        n_err++;
        $display("FAIL stall_req c=%0d: got %0b want %0b", c, imem_req_o, exp_req);
      end
      if (c >= 2) begin
        n_vec++;
        if ({fd_valid_o, fd_pc_o, fd_instr_o} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          n_err++;
          $display("FAIL stall_fd c=%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h",
                   c, fd_valid_o, fd_pc_o, fd_instr_o, exp_pc);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (imem_addr_o !== 32'h10) begin
          n_err++;
          $display("FAIL stall_release_addr: got %h want 00000010", imem_addr_o);
        end
      end
      next_cycle();
    end
    f_stall_i = 1'b0;
  endtask

  // One pass then four stall+flush cycles: exactly one valid per period
  task automatic test_control_flow();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      f_stall_i  = (k % 5 != 0);
      fd_flush_i = (k % 5 != 0);
      #1;
      exp_v  = (k >= 6) && (k % 5 == 1);
      exp_pc = 32'(4 * ((k - 6) / 5));
      n_vec++;
      if (fd_valid_o !== exp_v) begin
        n_err++;
        $display("FAIL cf_valid k=%0d: got %0b want %0b", k, fd_valid_o, exp_v);
      end else if (exp_v && (fd_pc_o !== exp_pc || fd_instr_o !== mem_word(exp_pc))) begin
        n_err++;
        $display("FAIL cf_pc k=%0d: got pc=%h ins=%h want pc=%h", k, fd_pc_o, fd_instr_o, exp_pc);
      end
      next_cycle();
    end
    f_stall_i  = 1'b0;
    fd_flush_i = 1'b0;
  endtask

  // Redirect in cycle 3 with buffer holding pc 4 and stall high
  task automatic test_redirect();
    do_reset();
    next_cycle();            // cycle 1
    next_cycle();            // cycle 2
    f_stall_i = 1'b1;
    next_cycle();            // cycle 3
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h100;
    #1;
    n_vec++;
    if (imem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_noissue: got req=%0b want 0", imem_req_o);
    end
    next_cycle();            // cycle 4
    redirect_valid_i = 1'b0;
    f_stall_i = 1'b0;
    #1;
    n_vec++;
    if ({fd_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL redir_n1: got v=%0b req=%0b addr=%h want v=0 req=1 addr=00000100",
               fd_valid_o, imem_req_o, imem_addr_o);
    end
    next_cycle();            // cycle 5
    n_vec++;
    if (fd_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL redir_n2: got v=%0b want 0 (stale buffer leaked?) pc=%h",
               fd_valid_o, fd_pc_o);
    end
    next_cycle();            // cycle 6
    n_vec++;
    if ({fd_valid_o, fd_pc_o, fd_instr_o} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
      n_err++;
      $display("FAIL redir_n3: got v=%0b pc=%h ins=%h want v=1 pc=00000100",
               fd_valid_o, fd_pc_o, fd_instr_o);
    end
    next_cycle();            // cycle 7
    n_vec++;
    if ({fd_valid_o, fd_pc_o} !== {1'b1, 32'h104}) begin
      n_err++;
      $display("FAIL redir_n4: got v=%0b pc=%h want v=1 pc=00000104", fd_valid_o, fd_pc_o);
    end
  endtask

  // PC wrap at the top of the address space, and a misaligned target
  task automatic test_wrap_misaligned();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004;
    do_reset();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFF8;
    next_cycle();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (imem_addr_o !== exp_addr[i]) begin
        n_err++;
        $display("FAIL wrap_addr i=%0d: got %h want %h", i, imem_addr_o, exp_addr[i]);
      end
      next_cycle();
    end
    // F/D now shows the word issued two cycles ago: 0x00000000 after wrap
    n_vec++;
    if ({fd_valid_o, fd_pc_o} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL wrap_fd: got v=%0b pc=%h want v=1 pc=00000000", fd_valid_o, fd_pc_o);
    end
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_0102;
    next_cycle();
    redirect_valid_i = 1'b0;
    next_cycle();
    n_vec++;
    if (imem_addr_o !== 32'h0000_0106) begin
      n_err++;
      $display("FAIL misaligned_addr: got %h want 00000106", imem_addr_o);
    end
    next_cycle();
    n_vec++;
    if ({fd_valid_o, fd_pc_o} !== {1'b1, 32'h102}) begin
      n_err++;
      $display("FAIL misaligned_fd: got v=%0b pc=%h want v=1 pc=00000102", fd_valid_o, fd_pc_o);
    end
  endtask

  // Asynchronous reset mid-stall takes effect with no clock edge
  task automatic test_async_reset();
    do_reset();
    repeat (4) next_cycle();
    f_stall_i = 1'b1;
    next_cycle();
    #2;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if ({fd_valid_o, fd_pc_o, fd_instr_o, imem_req_o, imem_addr_o} !==
        {1'b0, 32'h0, NOP_INSTR, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b pc=%h ins=%h req=%0b addr=%h want reset values",
               fd_valid_o, fd_pc_o, fd_instr_o, imem_req_o, imem_addr_o);
    end
    next_cycle();
    rst_i = 1'b0;
    f_stall_i = 1'b0;
    #1;
    n_vec++;
    if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL async_restart: got req=%0b addr=%h want req=1 addr=00000000",
               imem_req_o, imem_addr_o);
    end
    next_cycle();
    next_cycle();
    n_vec++;
    if ({fd_valid_o, fd_pc_o} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL async_refetch: got v=%0b pc=%h want v=1 pc=00000000", fd_valid_o, fd_pc_o);
    end
  endtask

`ifdef FETCH_PERF_EN
  // Cycles 2..11 of the control_flow pattern: valid in 6 and 11 only
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      f_stall_i  = (k % 5 != 0);
      fd_flush_i = (k % 5 != 0);
      next_cycle();
    end
    f_stall_i  = 1'b0;
    fd_flush_i = 1'b0;
    n_vec++;
    if ({fetch_cnt_o, bubble_cnt_o} !== {32'd2, 32'd8}) begin
      n_err++;
      $display("FAIL perf_cnt: got fetch=%0d bubble=%0d want fetch=2 bubble=8",
               fetch_cnt_o, bubble_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_control_flow();
    test_redirect();
    test_wrap_misaligned();
    test_async_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
